axi_chan_checker: RTL and testbench
===================================

Name: axi_chan_checker

Overview:
- Passive in-order scoreboard for the two ends of one AXI transport path, e.g. a manager port before a NoC chimney/bridge chain and the matching subordinate port after it.
- Every beat accepted on each of the five channels at the entry side must reappear unchanged, in order, at the exit side.
- Request channels (AW, W, AR) flow A->B; response channels (B, R) flow B->A.
- Transaction IDs are optionally excluded from the comparison, because the NoC remaps them.

Parameters:
- IgnoreId, 1'b1: exclude the .id field of AW/AR/B/R from comparison.
- FifoDepth, 64: expected-beat storage per channel (power of two, >=2).
- aw_chan_t, w_chan_t, b_chan_t, ar_chan_t, r_chan_t, default logic: AXI channel structs.
- req_t, rsp_t, default logic: AXI request/response structs containing the channel structs plus valid/ready.

Ports:
- clk_i, in, 1: single clock for both sides.
- rst_ni, in, 1: asynchronous, active-low reset.
- axi_a_req_i, in, req_t: side A (upstream manager) request, observed only.
- axi_a_rsp_i, in, rsp_t: side A response, observed only.
- axi_b_req_i, in, req_t: side B (downstream subordinate) request, observed only.
- axi_b_rsp_i, in, rsp_t: side B response, observed only.
- mismatch_o, out, 5: per-channel compare-failure pulse, bit order {R,AR,B,W,AW}.
- unexpected_o, out, 5: per-channel pulse for a beat arriving with no expected entry.
- overflow_o, out, 1: sticky; a push was attempted into a full FIFO.
- err_cnt_o, out, 32: saturating total of mismatch and unexpected events.
- idle_o, out, 1: all five FIFOs empty.

Behaviour:
- Reset state (async assert): FIFOs empty, mismatch_o=0, unexpected_o=0, overflow_o=0, err_cnt_o=0, idle_o=1.
- Handshake: a beat counts only when valid&ready is high at a rising clk_i edge. The block drives no AXI signal.
- Producer and consumer sides:
  - AW/W/AR: producer = A-side handshake, consumer = B-side handshake.
  - B/R: producer = B-side handshake (subordinate rsp), consumer = A-side handshake.
- Producer handshake: push the channel struct into that channel's FIFO.
- Consumer handshake with a non-empty FIFO: pop the head and compare it with the consumer beat.
- Compared fields:
  - With IgnoreId=1: all fields except .id. W has no id and is always compared in full.
  - With IgnoreId=0: the full struct.
- Inequality: mismatch_o[ch]=1 for exactly the cycle after the handshake (registered pulse, latency 1).
- Same-cycle push and pop on an empty FIFO: the consumer beat is compared against the producer beat directly (bypass); nothing is stored. Not unexpected.
- Same-cycle push and pop on a non-empty FIFO: compare against the head; count is unchanged.
- Consumer handshake with an empty FIFO and no bypass: unexpected_o[ch]=1 for one cycle; nothing is popped.
- Push into a full FIFO: the beat is dropped and overflow_o is set and held until reset. Pops continue.
- err_cnt_o: increments by popcount(mismatch|unexpected) per cycle and saturates at 2^32-1.
- Simulation-only (translate_off):
  - On each mismatch, $error with channel name, expected and actual values.
  - At $finish, $warning if idle_o=0.
- Reset mid-operation: all stored beats are discarded. No pulses are generated during or in the cycle after reset.
- Channels are fully independent. The checker imposes no cross-channel ordering; AW/W ordering is checked only within each channel.

Decomposition:
- Channel typedefs come from the existing AXI typedef package of the instantiating design; no new package.
- One sub-module, axi_chk_fifo: parameterised type, FifoDepth, push/pop/head/full/empty.
  - Instantiated five times, once per channel.
- Comparison and ID masking: a per-channel function in the top module. It copies the struct, zeroes .id when IgnoreId, then compares.

Test Plan:
- A-side AW addr=0x100 len=3 id=2, later B-side AW addr=0x100 len=3 id=5, IgnoreId=1 -> no mismatch; idle_o=1 afterwards.
- Same sequence with IgnoreId=0 -> mismatch_o=5'b00001 for one cycle; err_cnt_o=1.
- A-side W data=0xDEAD then 0xBEEF; B-side W data=0xDEAD then 0xBEE0 -> mismatch_o[1] pulse on the second beat only; err_cnt_o=1.
- B-side R beat with no A-side consumption pending, then A-side R with a different resp -> first beat is simply stored; A-side R handshake before any B-side R -> unexpected_o[4] pulse.
- Push 65 AR beats on A with no B-side consumption (FifoDepth=64) -> overflow_o=1 sticky; after 64 matching B-side ARs, no mismatch and idle_o=1.
- Same-cycle A and B AW handshakes with equal payload on an empty FIFO -> no pulses, idle_o stays 1. Assert rst_ni mid-stream with 10 pending beats -> outputs clear and idle_o=1 immediately.

Source files
------------

// File: rtl/axi_chan_checker_pkg.sv
// Shared constants, a popcount helper, and example AXI channel structs for axi_chan_checker.
// The structs are only parameter defaults; real users pass their own AXI typedefs.
package axi_chan_checker_pkg;

  localparam int unsigned NumCh = 5;
  localparam int unsigned ChAw  = 0;
  localparam int unsigned ChW   = 1;
  localparam int unsigned ChB   = 2;
  localparam int unsigned ChAr  = 3;
  localparam int unsigned ChR   = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } dflt_aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } dflt_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } dflt_b_t;

  typedef dflt_aw_t dflt_ar_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } dflt_r_t;

  typedef struct packed {
    dflt_aw_t aw;
    logic     aw_valid;
    dflt_w_t  w;
    logic     w_valid;
    logic     b_ready;
    dflt_ar_t ar;
    logic     ar_valid;
    logic     r_ready;
  } dflt_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    dflt_b_t b;
    logic    b_valid;
    logic    ar_ready;
    dflt_r_t r;
    logic    r_valid;
  } dflt_rsp_t;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/axi_chk_fifo.sv
// Expected-beat FIFO for one AXI channel. A push while full is accepted only when a
// pop happens in the same cycle; otherwise the beat is dropped (reported by the parent).
module axi_chk_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;
  T                mem_q [Depth];

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset: an entry is only read once cnt_q says it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_chan_checker.sv
// Passive in-order scoreboard between two ends of one AXI path: request beats flow A->B,
// response beats B->A, and every beat must reappear unchanged and in order on the far side.
module axi_chan_checker
  import axi_chan_checker_pkg::*;
#(
  parameter bit          IgnoreId       = 1'b1,
  parameter int unsigned FifoDepth      = 64,
  parameter bit          ReportMismatch = 1'b1,
  parameter type         aw_chan_t      = dflt_aw_t,
  parameter type         w_chan_t       = dflt_w_t,
  parameter type         b_chan_t       = dflt_b_t,
  parameter type         ar_chan_t      = dflt_ar_t,
  parameter type         r_chan_t       = dflt_r_t,
  parameter type         req_t          = dflt_req_t,
  parameter type         rsp_t          = dflt_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  req_t        axi_a_req_i,
  input  rsp_t        axi_a_rsp_i,
  input  req_t        axi_b_req_i,
  input  rsp_t        axi_b_rsp_i,
  output logic [4:0]  mismatch_o,
  output logic [4:0]  unexpected_o,
  output logic        overflow_o,
  output logic [31:0] err_cnt_o,
  output logic        idle_o
);

  // Handshake: a beat is transferred when valid and ready are both high at a rising
  // clk_i edge; valid/ready are only observed, never driven.
  logic [NumCh-1:0] prod, cons, push, pop, full, empty, eq;
  logic [NumCh-1:0] mismatch_q, mismatch_d, unexpected_q, unexpected_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      err_cnt_q, err_cnt_d;
  logic [2:0]       n_err;
  logic [32:0]      err_sum;

  aw_chan_t aw_head, aw_exp;
  w_chan_t  w_head,  w_exp;
  b_chan_t  b_head,  b_exp;
  ar_chan_t ar_head, ar_exp;
  r_chan_t  r_head,  r_exp;

  function automatic logic aw_eq(input aw_chan_t a, input aw_chan_t b);
    aw_chan_t x, y;
    x = a; y = b;
    if (IgnoreId) begin x.id = '0; y.id = '0; end
    return x == y;
  endfunction

  function automatic logic w_eq(input w_chan_t a, input w_chan_t b);
    return a == b;
  endfunction

  function automatic logic b_eq(input b_chan_t a, input b_chan_t b);
    b_chan_t x, y;
    x = a; y = b;
    if (IgnoreId) begin x.id = '0; y.id = '0; end
    return x == y;
  endfunction

  function automatic logic ar_eq(input ar_chan_t a, input ar_chan_t b);
    ar_chan_t x, y;
    x = a; y = b;
    if (IgnoreId) begin x.id = '0; y.id = '0; end
    return x == y;
  endfunction

  function automatic logic r_eq(input r_chan_t a, input r_chan_t b);
    r_chan_t x, y;
    x = a; y = b;
    if (IgnoreId) begin x.id = '0; y.id = '0; end
    return x == y;
  endfunction

  assign prod[ChAw] = axi_a_req_i.aw_valid & axi_a_rsp_i.aw_ready;
  assign cons[ChAw] = axi_b_req_i.aw_valid & axi_b_rsp_i.aw_ready;
  assign prod[ChW]  = axi_a_req_i.w_valid  & axi_a_rsp_i.w_ready;
  assign cons[ChW]  = axi_b_req_i.w_valid  & axi_b_rsp_i.w_ready;
  assign prod[ChB]  = axi_b_rsp_i.b_valid  & axi_b_req_i.b_ready;
  assign cons[ChB]  = axi_a_rsp_i.b_valid  & axi_a_req_i.b_ready;
  assign prod[ChAr] = axi_a_req_i.ar_valid & axi_a_rsp_i.ar_ready;
  assign cons[ChAr] = axi_b_req_i.ar_valid & axi_b_rsp_i.ar_ready;
  assign prod[ChR]  = axi_b_rsp_i.r_valid  & axi_b_req_i.r_ready;
  assign cons[ChR]  = axi_a_rsp_i.r_valid  & axi_a_req_i.r_ready;

  // An empty FIFO with a same-cycle producer beat is bypassed: compare directly, store nothing.
  assign push = prod & ~(cons & empty);
  assign pop  = cons & ~empty;

  assign aw_exp = empty[ChAw] ? axi_a_req_i.aw : aw_head;
  assign w_exp  = empty[ChW]  ? axi_a_req_i.w  : w_head;
  assign b_exp  = empty[ChB]  ? axi_b_rsp_i.b  : b_head;
  assign ar_exp = empty[ChAr] ? axi_a_req_i.ar : ar_head;
  assign r_exp  = empty[ChR]  ? axi_b_rsp_i.r  : r_head;

  assign eq[ChAw] = aw_eq(aw_exp, axi_b_req_i.aw);
  assign eq[ChW]  = w_eq(w_exp, axi_b_req_i.w);
  assign eq[ChB]  = b_eq(b_exp, axi_a_rsp_i.b);
  assign eq[ChAr] = ar_eq(ar_exp, axi_b_req_i.ar);
  assign eq[ChR]  = r_eq(r_exp, axi_a_rsp_i.r);

  axi_chk_fifo #(.T(aw_chan_t), .Depth(FifoDepth)) i_fifo_aw (
    .clk_i, .rst_ni, .push_i(push[ChAw]), .data_i(axi_a_req_i.aw), .pop_i(pop[ChAw]),
    .head_o(aw_head), .full_o(full[ChAw]), .empty_o(empty[ChAw]));
  axi_chk_fifo #(.T(w_chan_t), .Depth(FifoDepth)) i_fifo_w (
    .clk_i, .rst_ni, .push_i(push[ChW]), .data_i(axi_a_req_i.w), .pop_i(pop[ChW]),
    .head_o(w_head), .full_o(full[ChW]), .empty_o(empty[ChW]));
  axi_chk_fifo #(.T(b_chan_t), .Depth(FifoDepth)) i_fifo_b (
    .clk_i, .rst_ni, .push_i(push[ChB]), .data_i(axi_b_rsp_i.b), .pop_i(pop[ChB]),
    .head_o(b_head), .full_o(full[ChB]), .empty_o(empty[ChB]));
  axi_chk_fifo #(.T(ar_chan_t), .Depth(FifoDepth)) i_fifo_ar (
    .clk_i, .rst_ni, .push_i(push[ChAr]), .data_i(axi_a_req_i.ar), .pop_i(pop[ChAr]),
    .head_o(ar_head), .full_o(full[ChAr]), .empty_o(empty[ChAr]));
  axi_chk_fifo #(.T(r_chan_t), .Depth(FifoDepth)) i_fifo_r (
    .clk_i, .rst_ni, .push_i(push[ChR]), .data_i(axi_b_rsp_i.r), .pop_i(pop[ChR]),
    .head_o(r_head), .full_o(full[ChR]), .empty_o(empty[ChR]));

  always_comb begin
    mismatch_d   = cons & (~empty | prod) & ~eq;
    unexpected_d = cons & empty & ~prod;
    overflow_d   = overflow_q | (|(prod & full & ~cons));
    n_err        = popcount5(mismatch_q | unexpected_q);
    err_sum      = {1'b0, err_cnt_q} + 33'(n_err);
    err_cnt_d    = err_sum[32] ? '1 : err_sum[31:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mismatch_q   <= '0;
      unexpected_q <= '0;
      overflow_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      mismatch_q   <= mismatch_d;
      unexpected_q <= unexpected_d;
      overflow_q   <= overflow_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign mismatch_o   = mismatch_q;
  assign unexpected_o = unexpected_q;
  assign overflow_o   = overflow_q;
  assign err_cnt_o    = err_cnt_q;
  assign idle_o       = &empty;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (ReportMismatch && rst_ni) begin
      if (mismatch_d[ChAw]) $error("axi_chan_checker AW mismatch: exp %h act %h", aw_exp, axi_b_req_i.aw);
      if (mismatch_d[ChW])  $error("axi_chan_checker W mismatch: exp %h act %h", w_exp, axi_b_req_i.w);
      if (mismatch_d[ChB])  $error("axi_chan_checker B mismatch: exp %h act %h", b_exp, axi_a_rsp_i.b);
      if (mismatch_d[ChAr]) $error("axi_chan_checker AR mismatch: exp %h act %h", ar_exp, axi_b_req_i.ar);
      if (mismatch_d[ChR])  $error("axi_chan_checker R mismatch: exp %h act %h", r_exp, axi_a_rsp_i.r);
    end
  end

  final begin
    if (!idle_o) $warning("axi_chan_checker: beats still pending at end of simulation");
  end
`endif

endmodule

// File: tb/tb_axi_chan_checker.sv
// Directed bench for axi_chan_checker: one IgnoreId=1 instance and one IgnoreId=0
// instance share the same stimulus; each task checks its own scenario inline.
module tb_axi_chan_checker;
  import axi_chan_checker_pkg::*;

  logic        clk, rst_n;
  dflt_req_t   a_req, b_req;
  dflt_rsp_t   a_rsp, b_rsp;
  logic [4:0]  mm1, ux1, mm0, ux0;
  logic        ov1, ov0, idle1, idle0;
  logic [31:0] ec1, ec0;
  int          check_cnt, pass_cnt;

  axi_chan_checker #(.IgnoreId(1'b1), .FifoDepth(64), .ReportMismatch(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_a_req_i(a_req), .axi_a_rsp_i(a_rsp), .axi_b_req_i(b_req), .axi_b_rsp_i(b_rsp),
    .mismatch_o(mm1), .unexpected_o(ux1), .overflow_o(ov1), .err_cnt_o(ec1), .idle_o(idle1));

  axi_chan_checker #(.IgnoreId(1'b0), .FifoDepth(64), .ReportMismatch(1'b0)) dut_strict (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_a_req_i(a_req), .axi_a_rsp_i(a_rsp), .axi_b_req_i(b_req), .axi_b_rsp_i(b_rsp),
    .mismatch_o(mm0), .unexpected_o(ux0), .overflow_o(ov0), .err_cnt_o(ec0), .idle_o(idle0));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    a_req = '0; b_req = '0; a_rsp = '0; b_rsp = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    #3;
    check_cnt++; if (mm1 !== 5'b0) $display("FAIL reset_mismatch: got %b expected 00000", mm1); else pass_cnt++;
    check_cnt++; if (ux1 !== 5'b0) $display("FAIL reset_unexpected: got %b expected 00000", ux1); else pass_cnt++;
    check_cnt++; if (ov1 !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", ov1); else pass_cnt++;
    check_cnt++; if (ec1 !== 32'd0) $display("FAIL reset_err_cnt: got %0d expected 0", ec1); else pass_cnt++;
    check_cnt++; if (idle1 !== 1'b1) $display("FAIL reset_idle: got %b expected 1", idle1); else pass_cnt++;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_aw_id();
    a_req.aw = '{id: 4'd2, addr: 32'h100, len: 8'd3};
    a_req.aw_valid = 1'b1; a_rsp.aw_ready = 1'b1;
    step(); idle_bus();
    check_cnt++; if (idle1 !== 1'b0) $display("FAIL aw_pending_idle: got %b expected 0", idle1); else pass_cnt++;
    step();
    b_req.aw = '{id: 4'd5, addr: 32'h100, len: 8'd3};
    b_req.aw_valid = 1'b1; b_rsp.aw_ready = 1'b1;
    step(); idle_bus();
    check_cnt++; if (mm1 !== 5'b00000) $display("FAIL aw_ignore_id: got %b expected 00000", mm1); else pass_cnt++;
    check_cnt++; if (mm0 !== 5'b00001) $display("FAIL aw_strict_id: got %b expected 00001", mm0); else pass_cnt++;
    check_cnt++; if (idle1 !== 1'b1) $display("FAIL aw_idle_after: got %b expected 1", idle1); else pass_cnt++;
    step();
    check_cnt++; if (mm0 !== 5'b00000) $display("FAIL aw_strict_pulse_width: got %b expected 00000", mm0); else pass_cnt++;
    check_cnt++; if (ec0 !== 32'd1) $display("FAIL aw_strict_err_cnt: got %0d expected 1", ec0); else pass_cnt++;
    check_cnt++; if (ec1 !== 32'd0) $display("FAIL aw_ignore_err_cnt: got %0d expected 0", ec1); else pass_cnt++;
  endtask

  task automatic test_w();
    a_req.w_valid = 1'b1; a_rsp.w_ready = 1'b1;
    a_req.w = '{data: 32'hDEAD, strb: 4'hF, last: 1'b0};
    step();
    a_req.w = '{data: 32'hBEEF, strb: 4'hF, last: 1'b1};
    step(); idle_bus();
    b_req.w_valid = 1'b1; b_rsp.w_ready = 1'b1;
    b_req.w = '{data: 32'hDEAD, strb: 4'hF, last: 1'b0};
    step();
    check_cnt++; if (mm1 !== 5'b00000) $display("FAIL w_first_beat: got %b expected 00000", mm1); else pass_cnt++;
    b_req.w = '{data: 32'hBEE0, strb: 4'hF, last: 1'b1};
    step(); idle_bus();
    check_cnt++; if (mm1 !== 5'b00010) $display("FAIL w_second_beat: got %b expected 00010", mm1); else pass_cnt++;
    step();
    check_cnt++; if (ec1 !== 32'd1) $display("FAIL w_err_cnt: got %0d expected 1", ec1); else pass_cnt++;
  endtask

  task automatic test_r();
    b_rsp.r = '{id: 4'd1, data: 32'h55, resp: 2'b00, last: 1'b1};
    b_rsp.r_valid = 1'b1; b_req.r_ready = 1'b1;
    step(); idle_bus();
    check_cnt++; if (ux1 !== 5'b00000) $display("FAIL r_store_unexpected: got %b expected 00000", ux1); else pass_cnt++;
    check_cnt++; if (idle1 !== 1'b0) $display("FAIL r_store_idle: got %b expected 0", idle1); else pass_cnt++;
    a_rsp.r = '{id: 4'd1, data: 32'h55, resp: 2'b10, last: 1'b1};
    a_rsp.r_valid = 1'b1; a_req.r_ready = 1'b1;
    step();
    check_cnt++; if (mm1 !== 5'b10000) $display("FAIL r_resp_mismatch: got %b expected 10000", mm1); else pass_cnt++;
    step(); idle_bus();
    check_cnt++; if (ux1 !== 5'b10000) $display("FAIL r_unexpected: got %b expected 10000", ux1); else pass_cnt++;
    step();
    check_cnt++; if (ux1 !== 5'b00000) $display("FAIL r_unexpected_width: got %b expected 00000", ux1); else pass_cnt++;
    check_cnt++; if (ec1 !== 32'd3) $display("FAIL r_err_cnt: got %0d expected 3", ec1); else pass_cnt++;
    check_cnt++; if (idle1 !== 1'b1) $display("FAIL r_idle_after: got %b expected 1", idle1); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int bad;
    a_req.ar_valid = 1'b1; a_rsp.ar_ready = 1'b1;
    for (int i = 0; i < 65; i++) begin
      a_req.ar = '{id: 4'd3, addr: 32'(i), len: 8'd0};
      step();
      if (i == 63) begin
        check_cnt++; if (ov1 !== 1'b0) $display("FAIL ar_overflow_early: got %b expected 0", ov1); else pass_cnt++;
      end
    end
    idle_bus();
    check_cnt++; if (ov1 !== 1'b1) $display("FAIL ar_overflow_set: got %b expected 1", ov1); else pass_cnt++;
    bad = 0;
    b_req.ar_valid = 1'b1; b_rsp.ar_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      b_req.ar = '{id: 4'd7, addr: 32'(i), len: 8'd0};
      step();
      if (mm1 !== 5'b0 || ux1 !== 5'b0) bad++;
    end
    idle_bus();
    check_cnt++; if (bad !== 0) $display("FAIL ar_drain_errors: got %0d bad beats expected 0", bad); else pass_cnt++;
    check_cnt++; if (idle1 !== 1'b1) $display("FAIL ar_drain_idle: got %b expected 1", idle1); else pass_cnt++;
    step();
    check_cnt++; if (ov1 !== 1'b1) $display("FAIL ar_overflow_sticky: got %b expected 1", ov1); else pass_cnt++;
    check_cnt++; if (ec1 !== 32'd3) $display("FAIL ar_err_cnt: got %0d expected 3", ec1); else pass_cnt++;
  endtask

  task automatic test_bypass();
    a_req.aw = '{id: 4'd4, addr: 32'h200, len: 8'd1};
    b_req.aw = '{id: 4'd4, addr: 32'h200, len: 8'd1};
    a_req.aw_valid = 1'b1; a_rsp.aw_ready = 1'b1;
    b_req.aw_valid = 1'b1; b_rsp.aw_ready = 1'b1;
    #2;
    check_cnt++; if (idle1 !== 1'b1) $display("FAIL bypass_idle_during: got %b expected 1", idle1); else pass_cnt++;
    step(); idle_bus();
    check_cnt++; if (mm1 !== 5'b0) $display("FAIL bypass_mismatch: got %b expected 00000", mm1); else pass_cnt++;
    check_cnt++; if (ux1 !== 5'b0) $display("FAIL bypass_unexpected: got %b expected 00000", ux1); else pass_cnt++;
    check_cnt++; if (mm0 !== 5'b0) $display("FAIL bypass_strict_mismatch: got %b expected 00000", mm0); else pass_cnt++;
    check_cnt++; if (idle1 !== 1'b1) $display("FAIL bypass_idle: got %b expected 1", idle1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    a_req.w_valid = 1'b1; a_rsp.w_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_req.w = '{data: 32'(32'h1000 + i), strb: 4'hF, last: 1'b0};
      step();
    end
    idle_bus();
    check_cnt++; if (idle1 !== 1'b0) $display("FAIL rst_pending_idle: got %b expected 0", idle1); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    check_cnt++; if (idle1 !== 1'b1) $display("FAIL rst_idle_async: got %b expected 1", idle1); else pass_cnt++;
    check_cnt++; if (ec1 !== 32'd0) $display("FAIL rst_err_cnt: got %0d expected 0", ec1); else pass_cnt++;
    check_cnt++; if (ov1 !== 1'b0) $display("FAIL rst_overflow: got %b expected 0", ov1); else pass_cnt++;
    check_cnt++; if (mm1 !== 5'b0 || ux1 !== 5'b0) $display("FAIL rst_pulses: got %b/%b expected 00000/00000", mm1, ux1); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    check_cnt++; if (mm1 !== 5'b0 || ux1 !== 5'b0) $display("FAIL rst_after_pulses: got %b/%b expected 00000/00000", mm1, ux1); else pass_cnt++;
    check_cnt++; if (idle0 !== 1'b1) $display("FAIL rst_strict_idle: got %b expected 1", idle0); else pass_cnt++;
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_aw_id();
    test_w();
    test_r();
    test_overflow();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
